// File: rtl/ovf_pack_conv_if.sv
`default_nettype none
// ============================================================================
//  Module      : ovf_pack_conv_if
//  Description : Signal bundle for the ovf_pack_conv sample packer.
//                The master side drives samples and control (in_vld, in_data,
//                mode, flush, cnt_clr). The slave side (the packer) returns the
//                packed word (out_vld, out_data, out_ovf) and the overflow
//                event counter (ovf_cnt).
//  Revision    : 1.0  initial release
// ============================================================================
interface ovf_pack_conv_if #(
    parameter int IW    = 8,
    parameter int OW    = 4,
    parameter int LANES = 2,
    parameter int CNTW  = 8
);
    // sample side
    logic                  in_vld;
    logic [IW-1:0]         in_data;
    logic [1:0]            mode;
    logic                  flush;
    logic                  cnt_clr;

    // packed word side
    logic                  out_vld;
    logic [LANES*OW-1:0]   out_data;
    logic                  out_ovf;
    logic [CNTW-1:0]       ovf_cnt;

    modport master (
        output in_vld,
        output in_data,
        output mode,
        output flush,
        output cnt_clr,
        input  out_vld,
        input  out_data,
        input  out_ovf,
        input  ovf_cnt
    );

    modport slave (
        input  in_vld,
        input  in_data,
        input  mode,
        input  flush,
        input  cnt_clr,
        output out_vld,
        output out_data,
        output out_ovf,
        output ovf_cnt
    );
endinterface
`default_nettype wire

// File: rtl/ovf_pack_conv.sv
`default_nettype none
// ============================================================================
//  Module      : ovf_pack_conv
//  Description : Narrows IW-bit samples to OW-bit lanes using one of four
//                overflow modes (TRUNC, USAT, SSAT, SWRAP) and packs LANES
//                converted samples into one LANES*OW output word, lane 0 in
//                the LSBs. Reports a per-word overflow flag and keeps a
//                saturating count of overflowing samples.
//  Ports       : clk      - clock, rising edge
//                rst_n    - asynchronous reset, active low
//                bus      - ovf_pack_conv_if.slave
//                  in_vld   sample valid, accepted every cycle (no backpressure)
//                  in_data  IW-bit sample
//                  mode     conversion mode, sampled with in_vld
//                  flush    emit the partially filled word
//                  cnt_clr  synchronous clear of ovf_cnt
//                  out_vld  one-cycle pulse, out_data/out_ovf valid
//                  out_data packed word (held until the next word)
//                  out_ovf  OR of lane overflow flags of this word
//                  ovf_cnt  overflowing samples since reset/clear, saturating
//  Revision    : 1.0  initial release
// ============================================================================
module ovf_pack_conv #(
    parameter int IW    = 8,
    parameter int OW    = 4,
    parameter int LANES = 2,
    parameter int CNTW  = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    ovf_pack_conv_if.slave    bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                c_KW      = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [c_KW-1:0]   c_LAST    = c_KW'(LANES - 1);
    localparam logic [CNTW-1:0]   c_CNT_MAX = {CNTW{1'b1}};

    localparam logic [1:0]        c_TRUNC   = 2'd0;
    localparam logic [1:0]        c_USAT    = 2'd1;
    localparam logic [1:0]        c_SSAT    = 2'd2;
    localparam logic [1:0]        c_SWRAP   = 2'd3;

    // ------------------------------------------------------------------------
    // Sample conversion (combinational)
    // ------------------------------------------------------------------------
    logic [OW-1:0] w_conv;
    logic          w_ov;

    if (IW > OW) begin : g_narrow
        localparam logic [OW-1:0] c_UMAX = {OW{1'b1}};
        // Most negative OW-bit value; written as a shift so OW=1 stays legal.
        localparam logic [OW-1:0] c_SMIN = OW'(1) << (OW - 1);
        localparam logic [OW-1:0] c_SMAX = ~c_SMIN;

        logic [IW-OW-1:0] w_hi;      // bits dropped by the narrowing
        logic [IW-OW:0]   w_sgn_hi;  // dropped bits plus the new sign bit
        logic             w_hi_any;
        logic             w_sfits;   // value representable in OW-bit signed

        assign w_hi     = bus.in_data[IW-1:OW];
        assign w_sgn_hi = bus.in_data[IW-1:OW-1];
        assign w_hi_any = |w_hi;
        // A signed value fits when every dropped bit equals the new sign bit.
        assign w_sfits  = (&w_sgn_hi) | ~(|w_sgn_hi);

        always_comb begin
            w_conv = bus.in_data[OW-1:0];
            w_ov   = 1'b0;
            case (bus.mode)
                c_TRUNC: begin
                    w_ov = w_hi_any;
                end
                c_USAT: begin
                    w_ov = w_hi_any;
                    if (w_hi_any) begin
                        w_conv = c_UMAX;
                    end
                end
                c_SSAT: begin
                    w_ov = ~w_sfits;
                    if (!w_sfits) begin
                        w_conv = bus.in_data[IW-1] ? c_SMIN : c_SMAX;
                    end
                end
                c_SWRAP: begin
                    w_ov = ~w_sfits;
                end
                default: begin
                    w_ov = 1'b0;
                end
            endcase
        end
    end else begin : g_wide
        // Widening never overflows; only the signedness of the mode matters.
        logic w_unused_mode;
        assign w_unused_mode = bus.mode[0];

        always_comb begin
            w_ov = 1'b0;
            if (bus.mode[1]) begin
                w_conv = OW'($signed(bus.in_data));
            end else begin
                w_conv = OW'(bus.in_data);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Packing state
    //  r_buf / r_pend accumulate the word being filled. When a word closes
    //  (last lane written, or flush with something to emit) r_cmp is set and
    //  r_k returns to 0 on the same edge. During the following cycle r_buf
    //  still holds the closed word for the output register, while a new
    //  sample may already be written into lane 0 of a logically empty buffer;
    //  that is what lets words run back to back without a bubble.
    // ------------------------------------------------------------------------
    logic [LANES*OW-1:0] r_buf;
    logic [c_KW-1:0]     r_k;
    logic                r_pend;
    logic                r_cmp;

    logic                r_out_vld;
    logic [LANES*OW-1:0] r_out_data;
    logic                r_out_ovf;
    logic [CNTW-1:0]     r_cnt;

    logic [LANES*OW-1:0] w_buf_base;
    logic [LANES*OW-1:0] w_buf_nxt;
    logic                w_pend_nxt;
    logic                w_acc_ov;
    logic                w_close;
    logic [c_KW-1:0]     w_k_nxt;
    logic [CNTW-1:0]     w_cnt_nxt;

    assign w_acc_ov = bus.in_vld & w_ov;

    always_comb begin
        // A closed word is treated as already cleared for the next sample.
        w_buf_base = r_cmp ? '0 : r_buf;
        w_buf_nxt  = w_buf_base;
        for (int l = 0; l < LANES; l++) begin
            if (bus.in_vld && (r_k == c_KW'(l))) begin
                w_buf_nxt[l*OW +: OW] = w_conv;
            end
        end
        w_pend_nxt = (r_cmp ? 1'b0 : r_pend) | w_acc_ov;
    end

    // Word closes on the last lane, or on flush when the word is non-empty
    // after this cycle's sample. A flush on the completing sample is still a
    // single close.
    always_comb begin
        w_close = (bus.in_vld && (r_k == c_LAST)) ||
                  (bus.flush && ((r_k != '0) || bus.in_vld));
        if (w_close) begin
            w_k_nxt = '0;
        end else if (bus.in_vld) begin
            w_k_nxt = r_k + c_KW'(1);
        end else begin
            w_k_nxt = r_k;
        end
    end

    // Overflow counter: clear wins over hold, but an overflowing sample in the
    // clear cycle is itself counted.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (bus.cnt_clr) begin
            w_cnt_nxt = w_acc_ov ? CNTW'(1) : '0;
        end else if (w_acc_ov && (r_cnt != c_CNT_MAX)) begin
            w_cnt_nxt = r_cnt + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf      <= '0;
            r_k        <= '0;
            r_pend     <= 1'b0;
            r_cmp      <= 1'b0;
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_ovf  <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_buf     <= w_buf_nxt;
            r_k       <= w_k_nxt;
            r_pend    <= w_pend_nxt;
            r_cmp     <= w_close;
            r_cnt     <= w_cnt_nxt;
            r_out_vld <= r_cmp;
            if (r_cmp) begin
                r_out_data <= r_buf;
                r_out_ovf  <= r_pend;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.out_vld  = r_out_vld;
    assign bus.out_data = r_out_data;
    assign bus.out_ovf  = r_out_ovf;
    assign bus.ovf_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ovf_pack_conv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ovf_pack_conv
//  Description : Self-checking bench for ovf_pack_conv (IW=8, OW=4, LANES=2).
//                A second instance with CNTW=2 shares the same stimulus to
//                exercise counter saturation. Directed scenarios are followed
//                by randomized traffic checked against an arithmetic model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ovf_pack_conv;

    localparam int IW    = 8;
    localparam int OW    = 4;
    localparam int LANES = 2;
    localparam int CNTW  = 8;
    localparam int CNTW2 = 2;
    localparam int WW    = LANES * OW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ovf_pack_conv_if #(.IW(IW), .OW(OW), .LANES(LANES), .CNTW(CNTW))  bus  ();
    ovf_pack_conv_if #(.IW(IW), .OW(OW), .LANES(LANES), .CNTW(CNTW2)) bus2 ();

    assign bus2.in_vld  = bus.in_vld;
    assign bus2.in_data = bus.in_data;
    assign bus2.mode    = bus.mode;
    assign bus2.flush   = bus.flush;
    assign bus2.cnt_clr = bus.cnt_clr;

    ovf_pack_conv #(.IW(IW), .OW(OW), .LANES(LANES), .CNTW(CNTW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    ovf_pack_conv #(.IW(IW), .OW(OW), .LANES(LANES), .CNTW(CNTW2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    // ------------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------------
    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // ------------------------------------------------------------------------
    // Reference model: plain integer arithmetic on sample values
    // ------------------------------------------------------------------------
    int          lq[$];       // converted lanes of the word being filled
    bit          m_pend;
    int          m_cnt;
    int          m_cnt2;
    bit          cur_vld;     // expected outputs visible now
    logic [WW-1:0] cur_data;
    bit          cur_ovf;
    bit          nx_vld;      // word closed this edge, visible after the next
    logic [WW-1:0] nx_data;
    bit          nx_ovf;

    function automatic void ref_conv(input int v, input int m, output int c, output bit ov);
        int umax = (1 << OW) - 1;
        int smax = (1 << (OW - 1)) - 1;
        int smin = -(1 << (OW - 1));
        int s    = (v >= (1 << (IW - 1))) ? v - (1 << IW) : v;
        case (m)
            0: begin c = v & umax; ov = (v > umax); end
            1: begin ov = (v > umax); c = ov ? umax : v; end
            2: begin
                ov = (s > smax) || (s < smin);
                c  = ((s > smax) ? smax : (s < smin) ? smin : s) & umax;
            end
            default: begin c = v & umax; ov = (s > smax) || (s < smin); end
        endcase
    endfunction

    task automatic model_reset();
        lq.delete();
        m_pend   = 1'b0;
        m_cnt    = 0;
        m_cnt2   = 0;
        cur_vld  = 1'b0;
        cur_data = '0;
        cur_ovf  = 1'b0;
        nx_vld   = 1'b0;
        nx_data  = '0;
        nx_ovf   = 1'b0;
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, "_out_vld"},  64'(bus.out_vld),  64'(cur_vld));
        chk({pfx, "_out_data"}, 64'(bus.out_data), 64'(cur_data));
        chk({pfx, "_out_ovf"},  64'(bus.out_ovf),  64'(cur_ovf));
        chk({pfx, "_ovf_cnt"},  64'(bus.ovf_cnt),  64'(m_cnt));
        chk({pfx, "_ovf_cnt2"}, 64'(bus2.ovf_cnt), 64'(m_cnt2));
    endtask

    // One clock: drive inputs, step the model, compare every output.
    task automatic tick(input bit v, input int d, input int m, input bit f, input bit c);
        int  cv;
        bit  ov;
        logic [WW-1:0] w;
        bus.in_vld  = v;
        bus.in_data = IW'(d);
        bus.mode    = 2'(m);
        bus.flush   = f;
        bus.cnt_clr = c;
        @(posedge clk);
        #1;
        cur_vld = nx_vld;
        if (nx_vld) begin
            cur_data = nx_data;
            cur_ovf  = nx_ovf;
        end
        nx_vld = 1'b0;
        ov     = 1'b0;
        if (v) begin
            ref_conv(d, m, cv, ov);
            lq.push_back(cv);
            m_pend = m_pend | ov;
        end
        if (c) begin
            m_cnt  = (v && ov) ? 1 : 0;
            m_cnt2 = (v && ov) ? 1 : 0;
        end else if (v && ov) begin
            if (m_cnt  < (1 << CNTW)  - 1) m_cnt++;
            if (m_cnt2 < (1 << CNTW2) - 1) m_cnt2++;
        end
        if ((lq.size() == LANES) || (f && lq.size() > 0)) begin
            w = '0;
            for (int i = 0; i < lq.size(); i++) begin
                w = w | (WW'(lq[i]) << (i * OW));
            end
            nx_vld  = 1'b1;
            nx_data = w;
            nx_ovf  = m_pend;
            lq.delete();
            m_pend = 1'b0;
        end
        check_outputs("cyc");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, releases it.
    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        bus.in_vld  = 1'b0;
        bus.in_data = '0;
        bus.mode    = 2'd0;
        bus.flush   = 1'b0;
        bus.cnt_clr = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: TRUNC 0x01, 0x11 -> 0x11 with overflow, one cycle later
        tick(1'b1, 'h01, 0, 1'b0, 1'b0);
        tick(1'b1, 'h11, 0, 1'b0, 1'b0);
        chk("t1_vld_not_yet", 64'(bus.out_vld), 64'd0);
        chk("t1_cnt", 64'(bus.ovf_cnt), 64'd1);
        idle(1);
        chk("t1_vld", 64'(bus.out_vld), 64'd1);
        chk("t1_data", 64'(bus.out_data), 64'h11);
        chk("t1_ovf", 64'(bus.out_ovf), 64'd1);
        idle(1);

        // 2: USAT / SSAT word pairs, back to back
        tick(1'b1, 'h21, 1, 1'b0, 1'b0);
        tick(1'b1, 'h0C, 1, 1'b0, 1'b0);
        tick(1'b1, 'hF3, 2, 1'b0, 1'b0);
        chk("t2_usat_data", 64'(bus.out_data), 64'hCF);
        chk("t2_usat_ovf", 64'(bus.out_ovf), 64'd1);
        tick(1'b1, 'h05, 2, 1'b0, 1'b0);
        tick(1'b1, 'hFE, 2, 1'b0, 1'b0);
        chk("t2_ssat_data", 64'(bus.out_data), 64'h58);
        chk("t2_ssat_ovf", 64'(bus.out_ovf), 64'd1);
        tick(1'b1, 'h07, 2, 1'b0, 1'b0);
        idle(1);
        chk("t2_ssat2_data", 64'(bus.out_data), 64'h7E);
        chk("t2_ssat2_ovf", 64'(bus.out_ovf), 64'd0);

        // 3: SWRAP, only lane 0 overflows
        tick(1'b1, 'hF3, 3, 1'b0, 1'b0);
        tick(1'b1, 'hFA, 3, 1'b0, 1'b0);
        idle(1);
        chk("t3_data", 64'(bus.out_data), 64'hA3);
        chk("t3_ovf", 64'(bus.out_ovf), 64'd1);

        // 4: partial word flush, then an idle flush emits nothing
        tick(1'b1, 'h07, 0, 1'b0, 1'b0);
        tick(1'b0, 0, 0, 1'b1, 1'b0);
        idle(1);
        chk("t4_vld", 64'(bus.out_vld), 64'd1);
        chk("t4_data", 64'(bus.out_data), 64'h07);
        idle(1);
        tick(1'b0, 0, 0, 1'b1, 1'b0);
        idle(2);
        // flush with in_vld on lane 0, and flush on a completing sample
        tick(1'b1, 'h09, 0, 1'b1, 1'b0);
        tick(1'b1, 'h04, 1, 1'b0, 1'b0);
        tick(1'b1, 'h06, 1, 1'b1, 1'b0);
        idle(3);

        // 5: counter saturation on the CNTW=2 instance, clear with overflow
        tick(1'b0, 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) tick(1'b1, 'hFF, 0, 1'b0, 1'b0);
        chk("t5_sat", 64'(bus2.ovf_cnt), 64'd3);
        tick(1'b1, 'hFF, 0, 1'b0, 1'b1);
        chk("t5_clr_ov", 64'(bus2.ovf_cnt), 64'd1);
        idle(2);

        // 6: reset between lane 0 and lane 1 discards the partial word
        tick(1'b1, 'h35, 0, 1'b0, 1'b0);
        pulse_reset("t6_rst");
        tick(1'b1, 'h02, 0, 1'b0, 1'b0);
        tick(1'b1, 'h03, 0, 1'b0, 1'b0);
        idle(1);
        chk("t6_vld", 64'(bus.out_vld), 64'd1);
        chk("t6_data", 64'(bus.out_data), 64'h32);

        // Randomized traffic, with a continuous burst and one mid-run reset
        for (int i = 0; i < 400; i++) begin
            bit v, f, c;
            v = (i >= 100 && i < 130) ? 1'b1 : ($urandom_range(0, 9) < 7);
            f = ($urandom_range(0, 9) == 0);
            c = ($urandom_range(0, 19) == 0);
            tick(v, int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), f, c);
            if (i == 250) pulse_reset("rnd_rst");
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
